// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: architectural sizes used by the register
// file and the ALU, plus small helpers for register-index handling.
package rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int REG_N      = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_word_t;

  // ALU operation select, shared with the ALU that consumes the read ports.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  // x0 is hardwired to zero; any read or write naming it is special-cased.
  function automatic logic is_x0(input reg_addr_t addr);
    return (addr == '0);
  endfunction

endpackage

// File: rtl/regfile.sv
// RV32I integer register file: two combinational read ports, one write port,
// a registered debug read port, a per-register "written since reset" bitmap
// and a running count of committed writes.
module regfile #(
  parameter int XLEN  = rv32i_pkg::XLEN,
  parameter int REG_N = rv32i_pkg::REG_N
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [rv32i_pkg::REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [rv32i_pkg::REG_ADDR_W-1:0] i_rs2_addr,
  output logic [XLEN-1:0]                o_rs1_data,
  output logic [XLEN-1:0]                o_rs2_data,
  input  logic                           i_rd_wren,
  input  logic [rv32i_pkg::REG_ADDR_W-1:0] i_rd_addr,
  input  logic [XLEN-1:0]                i_rd_data,
  input  logic [rv32i_pkg::REG_ADDR_W-1:0] i_dbg_addr,
  output logic [XLEN-1:0]                o_dbg_data,
  output logic [REG_N-1:0]               o_written,
  output logic [31:0]                    o_wr_count
);

  import rv32i_pkg::*;

  // Indices beyond REG_N (only possible with a reduced REG_N) behave like x0.
  function automatic logic in_range(input reg_addr_t addr);
    return (int'(addr) < REG_N);
  endfunction

  logic [XLEN-1:0]  regs [REG_N];
  logic [REG_N-1:1] written;
  logic [31:0]      wr_count;
  logic [XLEN-1:0]  dbg_data;
  logic [XLEN-1:0]  dbg_read;
  logic             wr_commit;

  // A write only counts when enabled and aimed at a real register; reset
  // priority is applied in the sequential blocks below.
  always_comb begin
    wr_commit = 1'b0;
    if (i_rd_wren && !is_x0(i_rd_addr) && in_range(i_rd_addr)) begin
      wr_commit = 1'b1;
    end
  end

  // Read port 1: straight from storage, no bypass from the write port.
  always_comb begin
    o_rs1_data = '0;
    if (!is_x0(i_rs1_addr) && in_range(i_rs1_addr)) begin
      o_rs1_data = regs[i_rs1_addr];
    end
  end

  // Read port 2: identical to port 1 but fully independent.
  always_comb begin
    o_rs2_data = '0;
    if (!is_x0(i_rs2_addr) && in_range(i_rs2_addr)) begin
      o_rs2_data = regs[i_rs2_addr];
    end
  end

  // Debug read value presented to the debug register (pre-write contents).
  always_comb begin
    dbg_read = '0;
    if (!is_x0(i_dbg_addr) && in_range(i_dbg_addr)) begin
      dbg_read = regs[i_dbg_addr];
    end
  end

  // Register storage: reset clears everything and wins over a same-edge write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < REG_N; k++) begin
        regs[k] <= '0;
      end
    end else if (wr_commit) begin
      regs[i_rd_addr] <= i_rd_data;
    end
  end

  // Sticky per-register written flags; bit 0 is not stored at all.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      written <= '0;
    end else if (wr_commit) begin
      written[i_rd_addr] <= 1'b1;
    end
  end

  // Committed-write counter, free-running with natural 32-bit wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_count <= '0;
    end else if (wr_commit) begin
      wr_count <= wr_count + 32'd1;
    end
  end

  // Debug port samples the old register contents every edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dbg_data <= '0;
    end else begin
      dbg_data <= dbg_read;
    end
  end

  assign o_written  = {written, 1'b0};
  assign o_wr_count = wr_count;
  assign o_dbg_data = dbg_data;

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: stimulus pushes hand-computed expectations
// tagged with the cycle they apply to; a monitor compares them mid-cycle.
module tb_regfile;

  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        rd_wren;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [31:0] written;
  logic [31:0] wr_count;

  typedef enum {K_RS1, K_RS2, K_DBG, K_WRITTEN, K_COUNT} kind_e;

  typedef struct {
    string       name;
    int          cyc;
    kind_e       kind;
    logic [31:0] value;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   fails  = 0;

  regfile dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rs1_addr (rs1_addr),
    .i_rs2_addr (rs2_addr),
    .o_rs1_data (rs1_data),
    .o_rs2_data (rs2_data),
    .i_rd_wren  (rd_wren),
    .i_rd_addr  (rd_addr),
    .i_rd_data  (rd_data),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data),
    .o_written  (written),
    .o_wr_count (wr_count)
  );

  // Free-running 10 ns clock.
  initial forever #5 clk = ~clk;

  // Cycle index used to tag when each expectation becomes due.
  always @(posedge clk) cyc++;

  // Queue an expectation due 'delay' cycles after the current one.
  task automatic expectOutput(input string name, input kind_e kind,
                              input logic [31:0] value, input int delay);
    exp_t e;
    e.name  = name;
    e.cyc   = cyc + delay;
    e.kind  = kind;
    e.value = value;
    sb.push_back(e);
  endtask

  // Drive one cycle's worth of inputs just after the rising edge.
  task automatic applyStimulus(input logic r, input logic w,
                               input logic [4:0] wa, input logic [31:0] wd,
                               input logic [4:0] a1, input logic [4:0] a2,
                               input logic [4:0] da);
    @(posedge clk);
    #1;
    rst      = r;
    rd_wren  = w;
    rd_addr  = wa;
    rd_data  = wd;
    rs1_addr = a1;
    rs2_addr = a2;
    dbg_addr = da;
  endtask

  // Compare one due expectation against what the DUT shows right now.
  task automatic checkOutput(input exp_t e);
    logic [31:0] actual;
    case (e.kind)
      K_RS1:     actual = rs1_data;
      K_RS2:     actual = rs2_data;
      K_DBG:     actual = dbg_data;
      K_WRITTEN: actual = written;
      default:   actual = wr_count;
    endcase
    checks++;
    if (e.cyc != cyc) begin
      fails++;
      $display("[TB] FAIL %s: checked in cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
    end else if (actual !== e.value) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", e.name, actual, e.value, cyc);
    end
  endtask

  // Monitor: at each falling edge, retire every expectation that is due.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checkOutput(e);
    end
  end

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence with hand-computed expectations.
  initial begin
    rst = 1'b1; rd_wren = 1'b0; rd_addr = '0; rd_data = '0;
    rs1_addr = '0; rs2_addr = '0; dbg_addr = '0;

    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);

    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 5'(i));
      expectOutput($sformatf("reset_rs1_x%0d", i), K_RS1, 32'h0, 0);
      expectOutput($sformatf("reset_rs2_x%0d", 31 - i), K_RS2, 32'h0, 0);
      if (i == 0) begin
        expectOutput("reset_written", K_WRITTEN, 32'h0, 0);
        expectOutput("reset_count", K_COUNT, 32'h0, 0);
        expectOutput("reset_dbg", K_DBG, 32'h0, 0);
      end
    end

    applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd0);
    expectOutput("x5_old_rs1", K_RS1, 32'h0, 0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
    expectOutput("x5_rs1", K_RS1, 32'hDEAD_BEEF, 0);
    expectOutput("x5_rs2", K_RS2, 32'hDEAD_BEEF, 0);
    expectOutput("x5_written", K_WRITTEN, 32'h0000_0020, 0);
    expectOutput("x5_count", K_COUNT, 32'd1, 0);
    expectOutput("x5_dbg", K_DBG, 32'hDEAD_BEEF, 1);

    applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd5, 5'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    expectOutput("x0_rs1", K_RS1, 32'h0, 0);
    expectOutput("x0_rs2", K_RS2, 32'h0, 0);
    expectOutput("x0_written", K_WRITTEN, 32'h0000_0020, 0);
    expectOutput("x0_count", K_COUNT, 32'd1, 0);

    applyStimulus(1'b0, 1'b1, 5'd7, 32'h1, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b1, 5'd7, 32'h2, 5'd7, 5'd5, 5'd0);
    expectOutput("x7_old_rs1", K_RS1, 32'h1, 0);
    expectOutput("x7_other_rs2", K_RS2, 32'hDEAD_BEEF, 0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd0);
    expectOutput("x7_new_rs1", K_RS1, 32'h2, 0);
    expectOutput("x7_new_rs2", K_RS2, 32'h2, 0);
    expectOutput("x7_count", K_COUNT, 32'd3, 0);
    expectOutput("x7_written", K_WRITTEN, 32'h0000_00A0, 0);

    applyStimulus(1'b0, 1'b0, 5'bxxxxx, 32'h1234_5678, 5'd7, 5'd5, 5'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 5'd0);
    expectOutput("xaddr_rs1", K_RS1, 32'h2, 0);
    expectOutput("xaddr_rs2", K_RS2, 32'hDEAD_BEEF, 0);
    expectOutput("xaddr_count", K_COUNT, 32'd3, 0);
    expectOutput("xaddr_written", K_WRITTEN, 32'h0000_00A0, 0);

    applyStimulus(1'b1, 1'b1, 5'd3, 32'h55, 5'd3, 5'd7, 5'd7);
    applyStimulus(1'b0, 1'b1, 5'd9, 32'h99, 5'd3, 5'd7, 5'd7);
    expectOutput("rstwr_x3", K_RS1, 32'h0, 0);
    expectOutput("rstwr_x7", K_RS2, 32'h0, 0);
    expectOutput("rstwr_count", K_COUNT, 32'd0, 0);
    expectOutput("rstwr_written", K_WRITTEN, 32'h0, 0);
    expectOutput("rstwr_dbg", K_DBG, 32'h0, 0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd3, 5'd0);
    expectOutput("post_rst_x9", K_RS1, 32'h99, 0);
    expectOutput("post_rst_x3", K_RS2, 32'h0, 0);
    expectOutput("post_rst_count", K_COUNT, 32'd1, 0);
    expectOutput("post_rst_written", K_WRITTEN, 32'h0000_0200, 0);

    applyStimulus(1'b0, 1'b1, 5'd1, 32'h1111_1111, 5'd0, 5'd0, 5'd1);
    #1;
    force dut.wr_count = 32'hFFFF_FFFF;
    #1;
    release dut.wr_count;
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd9, 5'd1);
    expectOutput("wrap_count", K_COUNT, 32'h0, 0);
    expectOutput("wrap_rs1", K_RS1, 32'h1111_1111, 0);
    expectOutput("wrap_rs2", K_RS2, 32'h99, 0);
    expectOutput("wrap_written", K_WRITTEN, 32'h0000_0202, 0);
    expectOutput("wrap_dbg_old", K_DBG, 32'h0, 0);
    expectOutput("wrap_dbg_new", K_DBG, 32'h1111_1111, 1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL queue_drain: %0d expectations left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter XLEN, default 32: register width in bits.
REQ-002 Parameter REG_N, default 32: number of architectural registers, x0..x31.
REQ-003 Port i_clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port i_rst, input, 1: reset; synchronous, active-high.
REQ-005 Port i_rs1_addr, input, 5: read port 1 register index.
REQ-006 Port i_rs2_addr, input, 5: read port 2 register index.
REQ-007 Port o_rs1_data, output, XLEN: read port 1 data, feeds ALU operand 1.
REQ-008 Port o_rs2_data, output, XLEN: read port 2 data, feeds ALU operand 2.
REQ-009 Port i_rd_wren, input, 1: write enable.
REQ-010 Port i_rd_addr, input, 5: write register index.
REQ-011 Port i_rd_data, input, XLEN: write data from writeback.
REQ-012 Port i_dbg_addr, input, 5: debug read index.
REQ-013 Port o_dbg_data, output, XLEN: registered debug read data.
REQ-014 Port o_written, output, REG_N: per-register "written since reset" bitmap.
REQ-015 Port o_wr_count, output, 32: count of committed register writes.

Function
REQ-016 Reads on rs1/rs2 SHALL be combinational, zero latency: o_rsN_data = regs[i_rsN_addr].
REQ-017 Index 0 on any read port SHALL return 0 regardless of stored contents.
REQ-018 A write SHALL commit at the rising edge when i_rd_wren=1, i_rd_addr!=0, i_rst=0.
REQ-019 Writes to x0 SHALL be discarded: no storage change, no o_written change, no o_wr_count increment.
REQ-020 Same-cycle read and write of one index SHALL return the old value (read-before-write, no bypass), so no combinational path runs from i_rd_* to o_rs*_data.
REQ-021 o_dbg_data SHALL register regs[i_dbg_addr] (old value, 0 for index 0) each edge; latency 1 cycle.
REQ-022 o_written[k] SHALL set on the first committed write to xk and hold until reset; o_written[0] SHALL be constant 0.
REQ-023 o_wr_count SHALL increment by 1 per committed write and wrap from 0xFFFF_FFFF to 0.
REQ-024 Both read ports SHALL be independent; identical indices on rs1 and rs2 return identical data.
REQ-025 Unknown/X on i_rd_addr with i_rd_wren=0 SHALL NOT alter state.

Reset
REQ-026 While i_rst=1 at an edge, all regs, o_dbg_data, o_written and o_wr_count SHALL become 0.
REQ-027 Reset SHALL take priority over a simultaneous write; that write is dropped and not counted.
REQ-028 On the first edge after i_rst deasserts, writes SHALL commit normally.

Structure
REQ-029 XLEN, REG_N and REG_ADDR_W=5 SHALL live in shared package rv32i_pkg, also used by the ALU.
REQ-030 Storage SHALL be one flop array inside regfile; no sub-module is needed.

Verification
REQ-031 Reset, then read all 32 indices -> every o_rs*_data = 0, o_written = 0, o_wr_count = 0.
REQ-032 Write x5=0xDEAD_BEEF; next cycle rs1=5, rs2=5 -> both 0xDEAD_BEEF, o_written[5]=1, o_wr_count=1.
REQ-033 Write x0=0xFFFF_FFFF -> rs1=0 reads 0, o_written[0]=0, o_wr_count unchanged.
REQ-034 x7=0x1 held; same cycle write x7=0x2 with rs1=7 -> o_rs1_data=0x1 that cycle, 0x2 the next.
REQ-035 i_rst=1 and write x3=0x55 in same cycle -> x3 reads 0, o_wr_count=0.
REQ-036 Preload o_wr_count=0xFFFF_FFFF via force, commit write x1 -> o_wr_count=0; i_dbg_addr=1 -> o_dbg_data=x1 one cycle later.
